// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, owner tags and the
// winner-select rule (DMA priority with a CPU slot forced after a burst).
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int BURST_W = 4;

  // CPU takes the slot when DMA is absent or DMA has used up its burst allowance.
  function automatic logic cpu_wins(input logic cpu_req, input logic dma_req,
                                    input logic [BURST_W-1:0] burst,
                                    input logic [BURST_W-1:0] max_burst);
    return cpu_req && (!dma_req || (burst == max_burst));
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-port (CPU, DMA) arbiter in front of a single-port synchronous RAM.
// Each access walks IDLE -> ADDR -> DATA -> ACK with registered RAM controls.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  state_t               state, state_nx;
  owner_t               owner;
  logic [BURST_W-1:0]   burst;
  logic                 grant;
  logic                 pick_cpu;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    pick_cpu = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant    = 1'b1;
          pick_cpu = cpu_wins(cpu_req, dma_req, burst, MAX_B);
          state_nx = ADDR;
        end
      end
      ADDR:    state_nx = DATA;
      DATA:    state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_CPU;
      burst     <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_di    <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      ram_we  <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;

      if (state == IDLE) begin
        // The burst window only counts DMA grants that actually made the CPU wait.
        if (!cpu_req) burst <= '0;
        if (grant) begin
          owner    <= pick_cpu ? OWN_CPU : OWN_DMA;
          ram_addr <= pick_cpu ? cpu_addr  : dma_addr;
          ram_we   <= pick_cpu ? cpu_we    : dma_we;
          ram_di   <= pick_cpu ? cpu_wdata : dma_wdata;
          if (pick_cpu)     burst <= '0;
          else if (cpu_req) burst <= burst + BURST_W'(1);
        end
      end

      if (state == DATA) begin
        if (owner == OWN_CPU) begin
          cpu_rdata <= ram_do;
          cpu_ack   <= 1'b1;
        end else begin
          dma_rdata <= ram_do;
          dma_ack   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: queued requesters, a RAM model, a slot-level reference
// arbiter feeding a scoreboard, and a monitor that pops on every ack.
module tb_ram_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam logic [15:0] ADDR_RAM = 16'hC000;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          gap;
  } req_t;

  typedef struct {
    bit          own_dma;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          ack_cyc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, ram_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, ram_di, ram_do;
  logic              cpu_ack, dma_ack, ram_we;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t cpu_pq[$];
  req_t dma_pq[$];
  exp_t exp_q[$];
  int   cpu_acks[$];
  int   dma_acks[$];

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [15:0] addr,
                              input logic [7:0] wdata, input int gap);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.gap = gap;
    return r;
  endfunction

  function automatic req_t rnd_req(input int maxgap);
    req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = ADDR_RAM + 16'($urandom_range(0, 31));
    r.wdata = 8'($urandom);
    r.gap   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, maxgap));
    return r;
  endfunction

  // Synchronous RAM: write commits at the edge, read data appears the next cycle.
  initial begin
    logic [7:0] rd;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[16'hC010] = 8'h5A;
    forever begin
      @(posedge clk);
      rd = mem[ram_addr];
      if (ram_we) mem[ram_addr] = ram_di;
      ram_do <= rd;
    end
  end

  // Requesters: hold req and fields until ack, then move to the next queued item.
  initial begin
    logic ca, da;
    int cg, dg;
    cg = 0; dg = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    forever begin
      @(negedge clk);
      ca = cpu_ack; da = dma_ack;
      @(posedge clk); #2;
      if (rst) begin
        cpu_req = 0; dma_req = 0; cg = 0; dg = 0;
        cpu_pq.delete(); dma_pq.delete();
      end else begin
        if (cpu_req && ca) begin cpu_pq.delete(0); cpu_req = 0; end
        if (dma_req && da) begin dma_pq.delete(0); dma_req = 0; end
        if (!cpu_req && cpu_pq.size() > 0) begin
          if (cg >= cpu_pq[0].gap) begin
            cpu_req = 1; cpu_we = cpu_pq[0].we; cpu_addr = cpu_pq[0].addr;
            cpu_wdata = cpu_pq[0].wdata; cg = 0;
          end else cg++;
        end
        if (!dma_req && dma_pq.size() > 0) begin
          if (dg >= dma_pq[0].gap) begin
            dma_req = 1; dma_we = dma_pq[0].we; dma_addr = dma_pq[0].addr;
            dma_wdata = dma_pq[0].wdata; dg = 0;
          end else dg++;
        end
      end
    end
  end

  // Reference arbiter: one access per 4-cycle slot; pick the winner at slot start,
  // apply it to the reference memory in grant order, and push the expected ack.
  initial begin
    int   slot, streak;
    bit   cpu_win;
    exp_t t, cur;
    slot = 0; streak = 0;
    cur = '{own_dma: 0, we: 0, addr: '0, wdata: '0, rdata: '0, ack_cyc: 0};
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3);
    ref_mem[16'hC010] = 8'h5A;
    forever begin
      @(negedge clk);
      if (slot == 0) begin
        chk("idle_ram_we", ram_we, 0);
      end else if (slot == 3) begin
        chk("addr_ram_we", ram_we, cur.we);
        chk("addr_ram_addr", ram_addr, cur.addr);
        chk("addr_ram_di", ram_di, cur.wdata);
      end else if (slot == 2) begin
        chk("data_ram_we", ram_we, 0);
        chk("data_ram_addr", ram_addr, cur.addr);
      end
      if (rst) begin
        slot = 0; streak = 0; exp_q.delete();
      end else if (slot != 0) begin
        slot--;
      end else if (cpu_req || dma_req) begin
        cpu_win = cpu_req && (!dma_req || streak == MAX_BURST);
        if (cpu_win || !cpu_req) streak = 0;
        else streak++;
        t.own_dma = !cpu_win;
        t.we      = cpu_win ? cpu_we    : dma_we;
        t.addr    = cpu_win ? cpu_addr  : dma_addr;
        t.wdata   = cpu_win ? cpu_wdata : dma_wdata;
        t.rdata   = ref_mem[t.addr];
        t.ack_cyc = cyc + 3;
        if (t.we) ref_mem[t.addr] = t.wdata;
        exp_q.push_back(t);
        cur  = t;
        slot = 3;
      end else begin
        streak = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever an ack shows up and checks rdata hold.
  initial begin
    exp_t t;
    logic [7:0] cpu_hold, dma_hold;
    bit cpu_known, dma_known;
    cpu_known = 0; dma_known = 0; cpu_hold = '0; dma_hold = '0;
    forever begin
      @(negedge clk);
      chk("ack_overlap", cpu_ack && dma_ack, 0);
      if (!cpu_ack && cpu_known) chk("cpu_rdata_hold", cpu_rdata, cpu_hold);
      if (!dma_ack && dma_known) chk("dma_rdata_hold", dma_rdata, dma_hold);
      if (cpu_ack) cpu_acks.push_back(cyc);
      if (dma_ack) dma_acks.push_back(cyc);
      if (cpu_ack || dma_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {cpu_ack, dma_ack}, 0);
        end else begin
          t = exp_q.pop_front();
          chk("ack_owner", {cpu_ack, dma_ack}, t.own_dma ? 2'b01 : 2'b10);
          chk("ack_cycle", cyc, t.ack_cyc);
          if (!t.we) chk(t.own_dma ? "dma_rdata" : "cpu_rdata",
                         t.own_dma ? dma_rdata : cpu_rdata, t.rdata);
          if (t.own_dma) begin dma_known = !t.we; dma_hold = t.rdata; end
          else           begin cpu_known = !t.we; cpu_hold = t.rdata; end
        end
      end else if (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
        t = exp_q.pop_front();
        chk("missing_ack", cyc, t.ack_cyc);
      end
      if (rst) begin
        cpu_known = 1; dma_known = 1; cpu_hold = '0; dma_hold = '0;
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((cpu_pq.size() != 0 || dma_pq.size() != 0 || cpu_req || dma_req ||
            exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic start_test(output int t0);
    @(posedge clk); #1;
    cpu_acks.delete();
    dma_acks.delete();
    t0 = cyc;
  endtask

  function automatic int first_or(input int q[$], input int idx, input int t0);
    return (q.size() > idx) ? q[idx] - t0 : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_di", ram_di, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);

    // CPU read of a preloaded location: ack three cycles after the request.
    start_test(t0);
    cpu_pq.push_back(mk(1'b0, 16'hC010, 8'h00, 0));
    wait_drain(50);
    chk("t1_ack_cycle", first_or(cpu_acks, 0, t0), 3);
    chk("t1_rdata", cpu_rdata, 8'h5A);

    // Write then read back with req held through the IDLE after the first ack.
    start_test(t0);
    cpu_pq.push_back(mk(1'b1, 16'hC020, 8'h3C, 0));
    cpu_pq.push_back(mk(1'b0, 16'hC020, 8'h00, 0));
    wait_drain(50);
    chk("t2_ack0_cycle", first_or(cpu_acks, 0, t0), 3);
    chk("t2_ack1_cycle", first_or(cpu_acks, 1, t0), 7);
    chk("t2_readback", cpu_rdata, 8'h3C);

    // Simultaneous requests: DMA first.
    start_test(t0);
    dma_pq.push_back(mk(1'b0, 16'hC020, 8'h00, 0));
    cpu_pq.push_back(mk(1'b0, 16'hC010, 8'h00, 0));
    wait_drain(50);
    chk("t3_dma_ack_cycle", first_or(dma_acks, 0, t0), 3);
    chk("t3_cpu_ack_cycle", first_or(cpu_acks, 0, t0), 7);
    chk("t3_dma_rdata", dma_rdata, 8'h3C);

    // Continuous contention: four DMA slots, then the CPU is forced in.
    start_test(t0);
    for (int i = 0; i < 6; i++) dma_pq.push_back(mk(1'b0, 16'hC030 + 16'(i), 8'h00, 0));
    for (int i = 0; i < 2; i++) cpu_pq.push_back(mk(1'b0, 16'hC040 + 16'(i), 8'h00, 0));
    wait_drain(200);
    chk("t4_dma_ack3", first_or(dma_acks, 3, t0), 15);
    chk("t4_cpu_ack0", first_or(cpu_acks, 0, t0), 19);
    chk("t4_dma_ack4", first_or(dma_acks, 4, t0), 23);

    // Reset during a DMA read's DATA cycle: no ack, outputs cleared.
    start_test(t0);
    dma_pq.push_back(mk(1'b0, 16'hC010, 8'h00, 0));
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_dma_ack", dma_ack, 0);
    chk("t5_ram_addr", ram_addr, 0);
    chk("t5_ram_we", ram_we, 0);
    chk("t5_ram_di", ram_di, 0);
    chk("t5_cpu_rdata", cpu_rdata, 0);
    chk("t5_dma_rdata", dma_rdata, 0);
    start_test(t1);
    cpu_pq.push_back(mk(1'b0, 16'hC010, 8'h00, 0));
    wait_drain(50);
    chk("t5_cpu_ack_cycle", first_or(cpu_acks, 0, t1), 3);
    chk("t5_no_dma_ack", dma_acks.size(), 0);
    chk("t5_cpu_rdata_after", cpu_rdata, 8'h5A);

    // Randomized traffic; DMA mostly back-to-back so the burst limit engages.
    start_test(t0);
    for (int i = 0; i < 200; i++) begin
      cpu_pq.push_back(rnd_req(4));
      dma_pq.push_back(rnd_req(1));
    end
    wait_drain(20000);
    chk("rand_cpu_acks", cpu_acks.size(), 200);
    chk("rand_dma_acks", dma_acks.size(), 200);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port system RAM between two requesters: the CPU data port and the DMA engine (block copies, e.g. OAM/VRAM fill).
- Sits between the requesters and the RAM side of the memory map. Address decode (RAM vs IO region, `ADDR_RAM`) is done upstream, so only RAM-region requests reach this block.
- Sequences each RAM access through a fixed 4-state handshake with registered RAM controls and registered read data.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 8, data width
- MAX_BURST, 4, max consecutive DMA grants while cpu_req is pending before the CPU is forced a slot (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request; held with fields stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same as cpu_* for the DMA port
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_di  out  DATA_W  registered RAM write data
- ram_do  in  DATA_W  RAM read data, valid the cycle after the address is presented

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; cpu_ack=dma_ack=0; cpu_rdata=dma_rdata=0; ram_addr=0; ram_we=0; ram_di=0; burst count=0; owner=CPU.
- FSM: IDLE -> ADDR -> DATA -> ACK -> IDLE.
- IDLE:
  - Samples requests and picks a winner.
  - Registers the winner's addr, we and wdata into ram_addr, ram_we and ram_di, records the owner, then goes to ADDR.
  - If no request, stays in IDLE with ram_we=0.
- ADDR:
  - ram_we is high for exactly this cycle on writes. RAM commits the write at the end of this cycle.
  - ram_addr is held. Goes to DATA.
- DATA:
  - ram_do is valid. ram_we=0, ram_addr still held.
  - At the clock edge, the owner's rdata register takes ram_do (writes also load it; the value is don't-care). The owner's ack register is set to 1.
  - Goes to ACK.
- ACK:
  - Owner ack=1 for exactly this cycle. Requests are not sampled.
  - Ack clears at the edge; goes to IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle 0 gives ack in cycle 3.
  - Maximum rate is one access per 4 cycles.
  - rdata holds its value after ack until the next access by that same port.
- Handshake:
  - The requester keeps req and fields stable until it sees ack.
  - If req is still high in the IDLE cycle after ACK, that is a new access.
- Arbitration:
  - DMA has priority over CPU.
  - A 4-bit burst counter increments on each DMA grant made while cpu_req=1.
  - When the counter equals MAX_BURST and cpu_req=1, the CPU wins the next IDLE.
  - The counter clears on any CPU grant, or on an IDLE cycle with cpu_req=0.
- Simultaneous requests in the same IDLE cycle: DMA wins unless the counter has reached MAX_BURST.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge and no ack is issued.
  - A write whose ADDR cycle coincides with rst still completes, since ram_we is registered.
  - The requester must reissue.
- ram_we never asserts outside ADDR. ram_addr changes only on the IDLE->ADDR edge or on reset.

Decomposition:
- Shared include (alongside mem_map.v): state encodings (IDLE=0, ADDR=1, DATA=2, ACK=3) and the owner encoding (OWN_CPU=0, OWN_DMA=1).
- ADDR_RAM stays in mem_map.v. The bench uses it to pick legal addresses.
- No sub-module required. The winner-select logic (priority plus burst override) is small enough to stay inline.

Test Plan:
- CPU read, RAM[0xC010]=0x5A, cpu_req at cycle 0 -> ram_addr=0xC010 in cycles 1-2; ram_we=0 throughout; cpu_ack=1 in cycle 3 only; cpu_rdata=0x5A.
- CPU write 0x3C to 0xC020, then read back -> ram_we=1 only in cycle 1 with ram_di=0x3C; ack in cycles 3 and 7; second read returns 0x3C.
- cpu_req and dma_req both asserted at cycle 0 -> dma_ack in cycle 3; cpu_ack in cycle 7; dma_ack never coincides with cpu_ack.
- MAX_BURST=4, dma_req and cpu_req held continuously, with each port dropping and reasserting after its ack -> grant order D,D,D,D,C,D,...; first cpu_ack in cycle 19.
- rst asserted during a DMA read's DATA cycle -> no dma_ack; all outputs 0 the next cycle; a following CPU read completes in 4 cycles.
- cpu_req held high through the IDLE after ack -> a second access starts; ram_addr re-presented in the following ADDR cycle; second cpu_ack 4 cycles after the first.
